// File: rtl/rf_pkg.sv
// rf_pkg: shared register-file defaults, special register indices and index type.
package rf_pkg;
  localparam int RF_DATA_W   = 32;
  localparam int RF_ADDR_W   = 5;
  localparam int RF_SP_IDX   = 29;
  localparam int RF_SP_RESET = 128;
  localparam int RF_LINK_IDX = 31;
  typedef logic [RF_ADDR_W-1:0] reg_idx_t;
endpackage

// File: rtl/rf_scoreboard.sv
// rf_scoreboard: per-register busy bits; a new claim outranks a same-edge commit.
module rf_scoreboard #(
  parameter int ADDR_W = 5
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   set_en_i,
  input  logic [ADDR_W-1:0]      set_addr_i,
  input  logic [(1<<ADDR_W)-1:0] clr_vec_i,
  output logic [(1<<ADDR_W)-1:0] busy_o,
  output logic                   busy_any_o
);
  localparam int DEPTH = 1 << ADDR_W;
  logic [DEPTH-1:0] set_vec;
  always_comb set_vec = (set_en_i && set_addr_i != '0) ? DEPTH'(1) << set_addr_i : '0;
  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) busy_o <= '0;
    else busy_o <= (busy_o & ~clr_vec_i) | set_vec;
  assign busy_any_o = |busy_o;
endmodule

// File: rtl/reg_file_mp.sv
// reg_file_mp: multi-port register file with link port, optional bypass and busy scoreboard.
module reg_file_mp
  import rf_pkg::*;
#(
  parameter int DATA_W   = RF_DATA_W,
  parameter int ADDR_W   = RF_ADDR_W,
  parameter int NUM_RD   = 2,
  parameter int SP_IDX   = RF_SP_IDX,
  parameter int SP_RESET = RF_SP_RESET,
  parameter int LINK_IDX = RF_LINK_IDX,
  parameter bit BYPASS   = 1'b1
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr_i,
  output logic [NUM_RD*DATA_W-1:0] rd_data_o,
  output logic [NUM_RD-1:0]        rd_busy_o,
  input  logic                     wr_en_i,
  input  logic [ADDR_W-1:0]        wr_addr_i,
  input  logic [DATA_W-1:0]        wr_data_i,
  input  logic                     link_en_i,
  input  logic [DATA_W-1:0]        link_data_i,
  input  logic                     busy_set_i,
  input  logic [ADDR_W-1:0]        busy_addr_i,
  output logic                     busy_any_o
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] LINK_A = ADDR_W'(LINK_IDX);
  logic [DATA_W-1:0] regs [DEPTH];
  logic [DEPTH-1:0] busy, clr_vec;
  logic main_ok, link_ok;
  // The link port owns LINK_IDX on a collision, so the main write is dropped there.
  assign link_ok = link_en_i && LINK_A != '0;
  assign main_ok = wr_en_i && wr_addr_i != '0 && !(link_ok && wr_addr_i == LINK_A);
  always_comb clr_vec = (main_ok ? DEPTH'(1) << wr_addr_i : '0) | (link_ok ? DEPTH'(1) << LINK_A : '0);
  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= (i == SP_IDX) ? DATA_W'(SP_RESET) : '0;
    end else begin
      if (main_ok) regs[wr_addr_i] <= wr_data_i;
      if (link_ok) regs[LINK_A] <= link_data_i;
    end
  rf_scoreboard #(.ADDR_W(ADDR_W)) u_sb (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .set_en_i(busy_set_i),
    .set_addr_i(busy_addr_i),
    .clr_vec_i(clr_vec),
    .busy_o(busy),
    .busy_any_o(busy_any_o)
  );
  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] a;
    logic hit_l, hit_m;
    assign a = rd_addr_i[k*ADDR_W +: ADDR_W];
    assign hit_l = BYPASS && link_ok && a == LINK_A;
    assign hit_m = BYPASS && main_ok && a == wr_addr_i;
    assign rd_data_o[k*DATA_W +: DATA_W] = a == '0 ? '0 : hit_l ? link_data_i : hit_m ? wr_data_i : regs[a];
    // A register committing this cycle is already resolved when bypass forwards it.
    assign rd_busy_o[k] = a != '0 && busy[a] && !hit_l && !hit_m;
  end
endmodule
